// File: rtl/rvvi_retire_collector_pkg.sv
// Shared types for the RVVI retire collector: the trace record layout and checker state.
// XLEN/ILEN come from macros so the packed record width is fixed at package elaboration.
`ifndef RVVI_XLEN
`define RVVI_XLEN 32
`endif
`ifndef RVVI_ILEN
`define RVVI_ILEN 32
`endif

package rvvi_retire_pkg;
   localparam int PKG_XLEN   = `RVVI_XLEN;
   localparam int PKG_ILEN   = `RVVI_ILEN;
   localparam int DROP_CNT_W = 16;

   typedef enum logic {
      CHK_IDLE,
      CHK_TRACK
   } chk_state_e;

   typedef struct packed {
      logic [63:0]          order;
      logic [PKG_ILEN-1:0]  insn;
      logic [PKG_XLEN-1:0]  pc;
      logic                 trap;
      logic [1:0]           mode;
      logic                 rd_wb;
      logic [4:0]           rd;
      logic [PKG_XLEN-1:0]  rd_data;
   } rvvi_rec_t;
endpackage

// File: rtl/rvvi_retire_collector_if.sv
// Trace-lane inputs and the record handshake toward the coverage sampler.
// master = trace source + sampler side, slave = collector.
interface rvvi_retire_collector_if
   import rvvi_retire_pkg::*;
#(
   parameter int RETIRE = 2,
   parameter int XLEN   = 32,
   parameter int ILEN   = 32
) ();
   logic [RETIRE-1:0]      in_valid;
   logic [RETIRE*64-1:0]   in_order;
   logic [RETIRE*ILEN-1:0] in_insn;
   logic [RETIRE*XLEN-1:0] in_pc;
   logic [RETIRE-1:0]      in_trap;
   logic [RETIRE*2-1:0]    in_mode;
   logic [RETIRE-1:0]      in_rd_wb;
   logic [RETIRE*5-1:0]    in_rd;
   logic [RETIRE*XLEN-1:0] in_rd_data;
   logic                   out_valid;
   logic                   out_ready;
   rvvi_rec_t              out_rec;

   modport master (
      output in_valid, in_order, in_insn, in_pc, in_trap, in_mode,
             in_rd_wb, in_rd, in_rd_data, out_ready,
      input  out_valid, out_rec
   );

   modport slave (
      input  in_valid, in_order, in_insn, in_pc, in_trap, in_mode,
             in_rd_wb, in_rd, in_rd_data, out_ready,
      output out_valid, out_rec
   );
endinterface

// File: rtl/rvvi_mpush_fifo.sv
// Compacting multi-push / single-pop FIFO. A cycle's pushes are accepted all-or-nothing,
// with a same-cycle pop crediting one slot; the head is read from storage only (no fall-through).
module rvvi_mpush_fifo
   import rvvi_retire_pkg::*;
#(
   parameter int RETIRE = 2,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [RETIRE-1:0]        push_valid,
   input  rvvi_rec_t                push_rec [RETIRE],
   input  logic                     pop_ready,
   output logic                     out_valid,
   output rvvi_rec_t                out_rec,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     push_drop,
   output logic [$clog2(DEPTH):0]   push_n
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rvvi_rec_t         mem_q [DEPTH];
   rvvi_rec_t         mem_d [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     n;
   logic [CW-1:0]     free;
   logic [AW-1:0]     slot;
   logic              pop;
   logic              accept;

   always_comb begin
      mem_d    = mem_q;
      n        = '0;
      slot     = '0;
      pop      = (count_q != '0) && pop_ready;
      for (int i = 0; i < RETIRE; i++) begin
         n = n + CW'(push_valid[i]);
      end
      free     = CW'(DEPTH) - count_q + CW'(pop);
      accept   = (n <= free);
      // Valid lanes land at consecutive slots, lowest lane first.
      if (accept) begin
         for (int i = 0; i < RETIRE; i++) begin
            if (push_valid[i]) begin
               mem_d[wr_ptr_q + slot] = push_rec[i];
               slot = slot + AW'(1);
            end
         end
      end
      wr_ptr_d = accept ? wr_ptr_q + AW'(n) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q - CW'(pop) + (accept ? n : '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign out_valid = (count_q != '0);
   assign out_rec   = mem_q[rd_ptr_q];
   assign occupancy = count_q;
   assign push_drop = !accept;
   assign push_n    = n;
endmodule

// File: rtl/rvvi_retire_collector.sv
// Collects RVVI retire events from all lanes into one FIFO for the coverage sampler,
// flagging (never back-pressuring) loss and checking the order field for gaps or reuse.
module rvvi_retire_collector
   import rvvi_retire_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ILEN   = 32,
   parameter int RETIRE = 2,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   rvvi_retire_collector_if.slave  bus,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    overflow,
   output logic [DROP_CNT_W-1:0]   drop_cnt,
   output logic                    order_err,
   output logic [63:0]             err_expected,
   output logic [63:0]             err_actual
);
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int SUM_W = DROP_CNT_W + 1;

   rvvi_rec_t              lane_rec [RETIRE];
   logic                   push_drop;
   logic [CW-1:0]          push_n;
   logic [SUM_W-1:0]       drop_sum;

   chk_state_e             chk_state_q, chk_state_d;
   logic [63:0]            exp_q, exp_d;
   logic                   order_err_q, order_err_d;
   logic [63:0]            err_expected_q, err_expected_d;
   logic [63:0]            err_actual_q, err_actual_d;
   logic                   overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   generate
      for (genvar gi = 0; gi < RETIRE; gi++) begin : g_lane
         assign lane_rec[gi].order   = bus.in_order[64*gi +: 64];
         assign lane_rec[gi].insn    = bus.in_insn[ILEN*gi +: ILEN];
         assign lane_rec[gi].pc      = bus.in_pc[XLEN*gi +: XLEN];
         assign lane_rec[gi].trap    = bus.in_trap[gi];
         assign lane_rec[gi].mode    = bus.in_mode[2*gi +: 2];
         assign lane_rec[gi].rd_wb   = bus.in_rd_wb[gi];
         assign lane_rec[gi].rd      = bus.in_rd[5*gi +: 5];
         assign lane_rec[gi].rd_data = bus.in_rd_data[XLEN*gi +: XLEN];
      end
   endgenerate

   rvvi_mpush_fifo #(
      .RETIRE (RETIRE),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_valid (bus.in_valid),
      .push_rec   (lane_rec),
      .pop_ready  (bus.out_ready),
      .out_valid  (bus.out_valid),
      .out_rec    (bus.out_rec),
      .occupancy  (occupancy),
      .push_drop  (push_drop),
      .push_n     (push_n)
   );

   always_comb begin
      chk_state_d    = chk_state_q;
      exp_d          = exp_q;
      order_err_d    = order_err_q;
      err_expected_d = err_expected_q;
      err_actual_d   = err_actual_q;
      // Every event, dropped or not, resynchronises the expected order to its own order+1.
      for (int i = 0; i < RETIRE; i++) begin
         if (bus.in_valid[i]) begin
            if (chk_state_d == CHK_TRACK && lane_rec[i].order != exp_d && !order_err_d) begin
               err_expected_d = exp_d;
               err_actual_d   = lane_rec[i].order;
               order_err_d    = 1'b1;
            end
            exp_d       = lane_rec[i].order + 64'd1;
            chk_state_d = CHK_TRACK;
         end
      end

      overflow_d = overflow_q | push_drop;
      drop_sum   = {1'b0, drop_cnt_q} + SUM_W'(push_n);
      drop_cnt_d = drop_cnt_q;
      if (push_drop) begin
         drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chk_state_q    <= CHK_IDLE;
         exp_q          <= '0;
         order_err_q    <= 1'b0;
         err_expected_q <= '0;
         err_actual_q   <= '0;
         overflow_q     <= 1'b0;
         drop_cnt_q     <= '0;
      end else begin
         chk_state_q    <= chk_state_d;
         exp_q          <= exp_d;
         order_err_q    <= order_err_d;
         err_expected_q <= err_expected_d;
         err_actual_q   <= err_actual_d;
         overflow_q     <= overflow_d;
         drop_cnt_q     <= drop_cnt_d;
      end
   end

   assign overflow     = overflow_q;
   assign drop_cnt     = drop_cnt_q;
   assign order_err    = order_err_q;
   assign err_expected = err_expected_q;
   assign err_actual   = err_actual_q;
endmodule

// File: tb/tb_rvvi_retire_collector.sv
// Directed bench: stimulus pushes expected records into a scoreboard queue,
// a negedge monitor pops and compares every accepted output record.
module tb_rvvi_retire_collector;
   import rvvi_retire_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [4:0]  occupancy;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic        order_err;
   logic [63:0] err_expected;
   logic [63:0] err_actual;

   int n_cmp = 0;
   int n_err = 0;
   rvvi_rec_t sb[$];

   rvvi_retire_collector_if #(.RETIRE(2), .XLEN(32), .ILEN(32)) bus ();

   rvvi_retire_collector #(
      .XLEN(32), .ILEN(32), .RETIRE(2), .DEPTH(16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus          (bus),
      .occupancy    (occupancy),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt),
      .order_err    (order_err),
      .err_expected (err_expected),
      .err_actual   (err_actual)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic rvvi_rec_t mk_rec(input logic [63:0] ord, input int lane);
      rvvi_rec_t r;
      r.order   = ord;
      r.insn    = (ord[31:0] * 32'd3) ^ 32'h0000_0013;
      r.pc      = 32'h8000_0000 + (ord[31:0] << 2);
      r.trap    = ord[0] & ord[2];
      r.mode    = ord[2:1];
      r.rd_wb   = ~ord[3];
      r.rd      = ord[8:4] ^ 5'(lane);
      r.rd_data = ~ord[31:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_lane(input int lane, input rvvi_rec_t r);
      bus.in_order[64*lane +: 64]   = r.order;
      bus.in_insn[32*lane +: 32]    = r.insn;
      bus.in_pc[32*lane +: 32]      = r.pc;
      bus.in_trap[lane]             = r.trap;
      bus.in_mode[2*lane +: 2]      = r.mode;
      bus.in_rd_wb[lane]            = r.rd_wb;
      bus.in_rd[5*lane +: 5]        = r.rd;
      bus.in_rd_data[32*lane +: 32] = r.rd_data;
   endtask

   // One trace cycle; expected records are queued only when the push should be accepted.
   task automatic push_cycle(input logic [1:0] mask, input logic [63:0] o0,
                             input logic [63:0] o1, input bit accepted);
      rvvi_rec_t r;
      if (mask[0]) begin
         r = mk_rec(o0, 0);
         set_lane(0, r);
         if (accepted) sb.push_back(r);
      end
      if (mask[1]) begin
         r = mk_rec(o1, 1);
         set_lane(1, r);
         if (accepted) sb.push_back(r);
      end
      bus.in_valid = mask;
      @(posedge clk);
      #1;
      bus.in_valid = 2'b00;
   endtask

   task automatic do_reset();
      bus.in_valid = 2'b00;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      reset_n = 1'b1;
   endtask

   task automatic drain(input string name);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 60 && occupancy != 5'd0; i++) begin
         @(posedge clk);
         #1;
      end
      check({name, "_occ"}, 64'(occupancy), 64'd0);
      check({name, "_sb_left"}, 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.out_valid && bus.out_ready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rec: got order %0h, expected no record", bus.out_rec.order);
         end else begin
            rvvi_rec_t e;
            e = sb.pop_front();
            if (bus.out_rec !== e) begin
               n_err++;
               $display("FAIL rec: got %0h, expected %0h", bus.out_rec, e);
            end else begin
               $display("rec order=%0h pc=%0h ok", bus.out_rec.order, bus.out_rec.pc);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n        = 1'b0;
      bus.in_valid   = '0;
      bus.in_order   = '0;
      bus.in_insn    = '0;
      bus.in_pc      = '0;
      bus.in_trap    = '0;
      bus.in_mode    = '0;
      bus.in_rd_wb   = '0;
      bus.in_rd      = '0;
      bus.in_rd_data = '0;
      bus.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("rst_order_err", 64'(order_err), 64'd0);
      check("rst_err_exp", err_expected, 64'd0);
      check("rst_err_act", err_actual, 64'd0);
      reset_n = 1'b1;

      // Two lanes in one cycle, sampler always ready.
      bus.out_ready = 1'b1;
      push_cycle(2'b11, 64'd5, 64'd6, 1'b1);
      check("t1_occ2", 64'(occupancy), 64'd2);
      @(posedge clk); #1;
      check("t1_occ1", 64'(occupancy), 64'd1);
      @(posedge clk); #1;
      check("t1_occ0", 64'(occupancy), 64'd0);
      check("t1_order_err", 64'(order_err), 64'd0);

      // Gap detection with first-error capture.
      do_reset();
      bus.out_ready = 1'b1;
      push_cycle(2'b01, 64'd10, 64'd0, 1'b1);
      push_cycle(2'b01, 64'd11, 64'd0, 1'b1);
      check("t2_no_err", 64'(order_err), 64'd0);
      push_cycle(2'b01, 64'd13, 64'd0, 1'b1);
      check("t2_err", 64'(order_err), 64'd1);
      check("t2_err_exp", err_expected, 64'd12);
      check("t2_err_act", err_actual, 64'd13);
      push_cycle(2'b01, 64'd14, 64'd0, 1'b1);
      check("t2_err_exp_hold", err_expected, 64'd12);
      check("t2_err_act_hold", err_actual, 64'd13);
      drain("t2");

      // Fill to full, then an all-or-nothing drop.
      do_reset();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         push_cycle(2'b11, 64'(100 + 2*c), 64'(101 + 2*c), 1'b1);
      end
      check("t3_full_occ", 64'(occupancy), 64'd16);
      push_cycle(2'b11, 64'd116, 64'd117, 1'b0);
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
      check("t3_occ_after_drop", 64'(occupancy), 64'd16);
      check("t3_order_err", 64'(order_err), 64'd0);
      drain("t3");

      // Full FIFO with a same-cycle pop admits a single-lane push.
      do_reset();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         push_cycle(2'b11, 64'(200 + 2*c), 64'(201 + 2*c), 1'b1);
      end
      bus.out_ready = 1'b1;
      push_cycle(2'b01, 64'd216, 64'd0, 1'b1);
      check("t4_occ", 64'(occupancy), 64'd16);
      check("t4_overflow", 64'(overflow), 64'd0);
      check("t4_drop_cnt", 64'(drop_cnt), 64'd0);
      drain("t4");

      // Lane1 alone, then a 64-bit order wrap across lanes.
      do_reset();
      bus.out_ready = 1'b1;
      push_cycle(2'b10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      push_cycle(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      push_cycle(2'b01, 64'd1, 64'd0, 1'b1);
      check("t5_order_err", 64'(order_err), 64'd0);
      drain("t5");

      // Mid-operation reset discards entries and returns the checker to IDLE.
      do_reset();
      bus.out_ready = 1'b0;
      push_cycle(2'b11, 64'd50, 64'd51, 1'b1);
      push_cycle(2'b11, 64'd52, 64'd53, 1'b1);
      push_cycle(2'b01, 64'd60, 64'd0, 1'b1);
      check("t6_occ5", 64'(occupancy), 64'd5);
      check("t6_err_set", 64'(order_err), 64'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("t6_rst_valid", 64'(bus.out_valid), 64'd0);
      check("t6_rst_occ", 64'(occupancy), 64'd0);
      check("t6_rst_err", 64'(order_err), 64'd0);
      check("t6_rst_err_exp", err_expected, 64'd0);
      check("t6_rst_err_act", err_actual, 64'd0);
      sb.delete();
      reset_n = 1'b1;
      bus.out_ready = 1'b1;
      push_cycle(2'b01, 64'd999, 64'd0, 1'b1);
      push_cycle(2'b01, 64'd1000, 64'd0, 1'b1);
      check("t6_idle_no_err", 64'(order_err), 64'd0);
      push_cycle(2'b01, 64'd1005, 64'd0, 1'b1);
      check("t6_err_after", 64'(order_err), 64'd1);
      check("t6_err_exp", err_expected, 64'd1001);
      check("t6_err_act", err_actual, 64'd1005);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
